// File: rtl/lzw_dec.sv
// lzw_dec: LZW decoder; unpacks fixed-width MSB-first codes from a byte stream,
// rebuilds the prefix/append dictionary on the fly and emits characters via a LIFO.
module lzw_dec #(
    parameter int CODE_W     = 12,
    parameter int FIRST_CODE = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init_lzd,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    input  logic        in_last,
    output logic        in_ready,
    output logic        out_valid,
    output logic [7:0]  out_byte,
    input  logic        out_ready,
    output logic [11:0] out_cnt,
    output logic        lzd_done,
    output logic        lzd_err
);
    localparam int DEPTH = 1 << CODE_W;
    localparam int CW = $clog2(CODE_W + 8);
    localparam logic [CW-1:0] CODE_WC = CW'(CODE_W);
    localparam logic [CODE_W-1:0] FC = CODE_W'(FIRST_CODE);

    typedef enum logic [2:0] {IDLE, FETCH, CHECK, WALK, POP, UPDATE, DONE, ERR} state_t;

    state_t            state_q, state_d;
    logic [CODE_W-2:0] acc_q, acc_d;
    logic [CODE_W+6:0] acc_n;
    logic [CW-1:0]     cnt_q, cnt_d, cnt_n;
    logic              ended_q, ended_d, first_q, first_d;
    logic [CODE_W-1:0] code_q, code_d, code_n, cur_q, cur_d, prev_q, prev_d, tos;
    logic [7:0]        fc_q, fc_d, push_data;
    logic [CODE_W:0]   next_q, next_d, sp_q, sp_d;
    logic [11:0]       out_cnt_q, out_cnt_d;
    logic              push, dict_we;
    logic [7:0]        stack_mem [DEPTH];
    logic [CODE_W-1:0] prefix_mem [DEPTH];
    logic [7:0]        append_mem [DEPTH];

    assign tos       = sp_q[CODE_W-1:0] - 1'b1;
    assign in_ready  = state_q == FETCH && !ended_q;
    assign out_valid = state_q == POP;
    assign out_byte  = out_valid ? stack_mem[tos] : 8'h00;
    assign out_cnt   = out_cnt_q;
    assign lzd_done  = state_q == DONE;
    assign lzd_err   = state_q == ERR;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ended_d   = ended_q;
        first_d   = first_q;
        code_d    = code_q;
        cur_d     = cur_q;
        prev_d    = prev_q;
        fc_d      = fc_q;
        next_d    = next_q;
        sp_d      = sp_q;
        out_cnt_d = out_cnt_q;
        push      = 1'b0;
        push_data = 8'h00;
        dict_we   = 1'b0;
        acc_n     = {acc_q, in_byte};
        cnt_n     = cnt_q + CW'(8);
        code_n    = CODE_W'(acc_n >> (cnt_n - CODE_WC));
        case (state_q)
            FETCH: begin
                if (ended_q) begin
                    state_d = DONE;
                end else if (in_valid) begin
                    acc_d   = acc_n[CODE_W-2:0];
                    ended_d = in_last;
                    cnt_d   = cnt_n >= CODE_WC ? cnt_n - CODE_WC : cnt_n;
                    code_d  = cnt_n >= CODE_WC ? code_n : code_q;
                    state_d = cnt_n >= CODE_WC ? CHECK : FETCH;
                end
            end
            CHECK: begin
                if (first_q) begin
                    push      = 1'b1;
                    push_data = code_q[7:0];
                    fc_d      = code_q[7:0];
                    prev_d    = code_q;
                    state_d   = POP;
                end else if ({1'b0, code_q} < next_q) begin
                    cur_d   = code_q;
                    state_d = WALK;
                end else if ({1'b0, code_q} == next_q) begin
                    // KwKwK: string is prev + its own first char, which lands at the bottom
                    push      = 1'b1;
                    push_data = fc_q;
                    cur_d     = prev_q;
                    state_d   = WALK;
                end else begin
                    state_d = ERR;
                end
            end
            WALK: begin
                push      = 1'b1;
                push_data = cur_q >= FC ? append_mem[cur_q] : cur_q[7:0];
                cur_d     = cur_q >= FC ? prefix_mem[cur_q] : cur_q;
                fc_d      = cur_q >= FC ? fc_q : cur_q[7:0];
                state_d   = cur_q >= FC ? WALK : POP;
            end
            POP: begin
                if (out_ready) begin
                    sp_d      = sp_q - 1'b1;
                    out_cnt_d = out_cnt_q + 1'b1;
                    if (tos == '0) begin
                        first_d = 1'b0;
                        state_d = first_q ? FETCH : UPDATE;
                    end
                end
            end
            UPDATE: begin
                // saturates at 2**CODE_W: a full dictionary is frozen, never wrapped
                dict_we = !next_q[CODE_W];
                next_d  = next_q + {{CODE_W{1'b0}}, !next_q[CODE_W]};
                prev_d  = code_q;
                state_d = ended_q ? DONE : FETCH;
            end
            default: ;
        endcase
        if (push) sp_d = sp_q + 1'b1;
        if (init_lzd) begin
            state_d   = FETCH;
            acc_d     = '0;
            cnt_d     = '0;
            ended_d   = 1'b0;
            first_d   = 1'b1;
            next_d    = {1'b0, FC};
            sp_d      = '0;
            out_cnt_d = '0;
            push      = 1'b0;
            dict_we   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            ended_q   <= 1'b0;
            first_q   <= 1'b1;
            code_q    <= '0;
            cur_q     <= '0;
            prev_q    <= '0;
            fc_q      <= '0;
            next_q    <= {1'b0, FC};
            sp_q      <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ended_q   <= ended_d;
            first_q   <= first_d;
            code_q    <= code_d;
            cur_q     <= cur_d;
            prev_q    <= prev_d;
            fc_q      <= fc_d;
            next_q    <= next_d;
            sp_q      <= sp_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) stack_mem[sp_q[CODE_W-1:0]] <= push_data;
        if (dict_we) begin
            prefix_mem[next_q[CODE_W-1:0]] <= prev_q;
            append_mem[next_q[CODE_W-1:0]] <= fc_q;
        end
    end
endmodule

// File: tb/tb_lzw_dec.sv
// tb_lzw_dec: directed scenarios for lzw_dec with hand-computed character streams.
module tb_lzw_dec;
    logic        clk = 1'b0;
    logic        rst, init_lzd, in_valid, in_last, out_ready;
    logic        in_ready, out_valid, lzd_done, lzd_err;
    logic [7:0]  in_byte, out_byte;
    logic [11:0] out_cnt;
    int          errors = 0;
    int          checks = 0;
    int          stall_bad;
    bit          tmo, stall_mode, abort;
    logic [7:0]  got[$];

    always #5 clk = ~clk;

    lzw_dec dut (
        .clk(clk), .rst(rst), .init_lzd(init_lzd), .in_valid(in_valid), .in_byte(in_byte),
        .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid), .out_byte(out_byte),
        .out_ready(out_ready), .out_cnt(out_cnt), .lzd_done(lzd_done), .lzd_err(lzd_err)
    );

    function automatic string to_s(input logic [7:0] q[$]);
        string s = "";
        foreach (q[i]) s = $sformatf("%s%c", s, q[i]);
        return s;
    endfunction

    task automatic do_init;
        @(negedge clk) init_lzd = 1'b1;
        @(negedge clk) init_lzd = 1'b0;
    endtask

    task automatic drive(input logic [7:0] b[$]);
        for (int i = 0; i < b.size() && !abort; i++) begin
            int t = 0;
            in_valid = 1'b1;
            in_byte  = b[i];
            in_last  = (i == b.size() - 1);
            while (!in_ready && !abort && t < 2000) begin
                @(negedge clk);
                t++;
            end
            if (t >= 2000) begin
                tmo = 1'b1;
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic collect(input int budget);
        int k = 0;
        bit pst = 1'b0;
        logic [7:0] pb = 8'h00;
        got.delete();
        stall_bad = 0;
        while (!lzd_done && !lzd_err && k < budget) begin
            out_ready = stall_mode ? (k % 3 == 0) : 1'b1;
            if (pst && (!out_valid || out_byte !== pb)) stall_bad++;
            pst = out_valid && !out_ready;
            pb  = out_byte;
            if (out_valid && out_ready) got.push_back(out_byte);
            @(negedge clk);
            k++;
        end
        if (k >= budget) tmo = 1'b1;
        out_ready = 1'b1;
    endtask

    task automatic run(input logic [7:0] b[$], input int budget);
        tmo = 1'b0;
        fork
            drive(b);
            collect(budget);
        join
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_byte, out_cnt, lzd_done, lzd_err} !== 24'h0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=0", {in_ready, out_valid, out_byte, out_cnt, lzd_done, lzd_err});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_in_ready got=%b want=0", in_ready);
        end
        do_init;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL init_in_ready got=%b want=1", in_ready);
        end
    endtask

    task automatic test_basic;
        logic [7:0] b[$];
        b = '{8'h04, 8'h10, 8'h42};
        run(b, 500);
        checks++;
        if (to_s(got) != "AB" || tmo) begin
            errors++;
            $display("FAIL basic_data got=\"%s\" tmo=%b want=\"AB\"", to_s(got), tmo);
        end
        checks++;
        if ({lzd_done, lzd_err} !== 2'b10) begin
            errors++;
            $display("FAIL basic_flags got done/err=%b want=10", {lzd_done, lzd_err});
        end
        checks++;
        if (out_cnt !== 12'd2) begin
            errors++;
            $display("FAIL basic_cnt got=%0d want=2", out_cnt);
        end
    endtask

    task automatic test_kwkwk;
        logic [7:0] b[$];
        b = '{8'h04, 8'h10, 8'h42, 8'h10, 8'h01, 8'h02};
        do_init;
        run(b, 500);
        checks++;
        if (to_s(got) != "ABABABA" || tmo) begin
            errors++;
            $display("FAIL kwkwk_data got=\"%s\" tmo=%b want=\"ABABABA\"", to_s(got), tmo);
        end
        checks++;
        if ({out_cnt, lzd_done, lzd_err} !== {12'd7, 2'b10}) begin
            errors++;
            $display("FAIL kwkwk_status got cnt=%0d done=%b err=%b want cnt=7 done=1 err=0", out_cnt, lzd_done, lzd_err);
        end
    endtask

    task automatic test_stall;
        logic [7:0] b[$];
        b = '{8'h04, 8'h10, 8'h42, 8'h10, 8'h01, 8'h02};
        do_init;
        stall_mode = 1'b1;
        run(b, 1000);
        stall_mode = 1'b0;
        checks++;
        if (to_s(got) != "ABABABA" || tmo) begin
            errors++;
            $display("FAIL stall_data got=\"%s\" tmo=%b want=\"ABABABA\"", to_s(got), tmo);
        end
        checks++;
        if (stall_bad != 0) begin
            errors++;
            $display("FAIL stall_stable got=%0d unstable cycles want=0", stall_bad);
        end
        checks++;
        if (out_cnt !== 12'd7) begin
            errors++;
            $display("FAIL stall_cnt got=%0d want=7", out_cnt);
        end
    endtask

    task automatic test_err;
        logic [7:0] b[$];
        int v = 0;
        b = '{8'h04, 8'h13, 8'h00};
        do_init;
        run(b, 500);
        checks++;
        if (to_s(got) != "A" || tmo) begin
            errors++;
            $display("FAIL err_data got=\"%s\" tmo=%b want=\"A\"", to_s(got), tmo);
        end
        repeat (5) begin
            if (out_valid !== 1'b0 || in_ready !== 1'b0 || lzd_err !== 1'b1) v++;
            @(negedge clk);
        end
        checks++;
        if (v != 0) begin
            errors++;
            $display("FAIL err_hold got=%0d bad cycles (valid=%b ready=%b err=%b) want=0", v, out_valid, in_ready, lzd_err);
        end
        do_init;
        checks++;
        if ({lzd_err, lzd_done, in_ready} !== 3'b001) begin
            errors++;
            $display("FAIL err_clear got err/done/ready=%b want=001", {lzd_err, lzd_done, in_ready});
        end
    endtask

    task automatic test_rst_mid;
        logic [7:0] b[$];
        int t = 0;
        b = '{8'h04, 8'h10, 8'h42, 8'h10, 8'h01, 8'h02};
        out_ready = 1'b1;
        abort = 1'b0;
        fork
            drive(b);
            begin
                while (out_cnt != 12'd4 && t < 500) begin
                    @(negedge clk);
                    t++;
                end
                repeat (3) @(negedge clk);
                rst = 1'b1;
                #1;
                checks++;
                if (t >= 500 || {in_ready, out_valid, out_byte, out_cnt, lzd_done, lzd_err} !== 24'h0) begin
                    errors++;
                    $display("FAIL rst_mid got=%h t=%0d want=0", {in_ready, out_valid, out_byte, out_cnt, lzd_done, lzd_err}, t);
                end
                abort = 1'b1;
            end
        join
        @(negedge clk);
        rst   = 1'b0;
        abort = 1'b0;
        do_init;
        run(b, 500);
        checks++;
        if (to_s(got) != "ABABABA" || tmo || out_cnt !== 12'd7) begin
            errors++;
            $display("FAIL rst_rerun got=\"%s\" cnt=%0d tmo=%b want=\"ABABABA\" cnt=7", to_s(got), out_cnt, tmo);
        end
    endtask

    task automatic test_full;
        logic [11:0] c[$];
        logic [7:0]  b[$];
        logic [7:0]  exp[$];
        int bad = 0;
        int first_bad = -1;
        for (int i = 0; i < 3841; i++) begin
            c.push_back(i % 2 != 0 ? 12'd66 : 12'd65);
            exp.push_back(i % 2 != 0 ? 8'h42 : 8'h41);
        end
        c.push_back(12'd67);
        c.push_back(12'd68);
        c.push_back(12'd4095);
        c.push_back(12'd256);
        exp.push_back(8'h43);
        exp.push_back(8'h44);
        exp.push_back(8'h42);
        exp.push_back(8'h41);
        exp.push_back(8'h41);
        exp.push_back(8'h42);
        for (int i = 0; i < c.size(); i += 2) begin
            b.push_back(c[i][11:4]);
            if (i + 1 < c.size()) begin
                b.push_back({c[i][3:0], c[i+1][11:8]});
                b.push_back(c[i+1][7:0]);
            end else begin
                b.push_back({c[i][3:0], 4'h0});
            end
        end
        do_init;
        run(b, 60000);
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            if (got[i] !== exp[i]) begin
                if (first_bad < 0) first_bad = i;
                bad++;
            end
        end
        checks++;
        if (got.size() != exp.size() || tmo) begin
            errors++;
            $display("FAIL full_len got=%0d tmo=%b want=%0d", got.size(), tmo, exp.size());
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL full_data got=%0d wrong chars (first at %0d) want=0", bad, first_bad);
        end
        checks++;
        if ({out_cnt, lzd_done, lzd_err} !== {12'd3847, 2'b10}) begin
            errors++;
            $display("FAIL full_status got cnt=%0d done=%b err=%b want cnt=3847 done=1 err=0", out_cnt, lzd_done, lzd_err);
        end
    endtask

    initial begin
        rst        = 1'b1;
        init_lzd   = 1'b0;
        in_valid   = 1'b0;
        in_byte    = 8'h00;
        in_last    = 1'b0;
        out_ready  = 1'b1;
        abort      = 1'b0;
        tmo        = 1'b0;
        stall_mode = 1'b0;
        test_reset;
        test_basic;
        test_kwkwk;
        test_stall;
        test_err;
        test_rst_mid;
        test_full;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
